booth_mul_ctrl_4bit: RTL

Sequential radix-2 Booth controller that produces a signed 4×4 → 8-bit product.
- Multiplication is done by repeatedly sequencing a 5-bit add/subtract step (add_sub_select semantics: 0 = add, 1 = subtract) followed by an arithmetic right shift.
- The block sits between the top-level operand registers and the result bus of the multiplier design, as the sequential alternative to the combinational array multiplier.
- One operation runs at a time, with a start/busy/done handshake.

---
 rtl/booth_mul_ctrl_4bit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/booth_mul_ctrl_4bit.sv
// booth_mul_ctrl_4bit
// Sequential radix-2 Booth multiplier for signed 4-bit operands.
// Each of the four iterations is one CALC cycle (conditional add/subtract of
// the 5-bit multiplicand into the accumulator) followed by one SHIFT cycle
// (arithmetic right shift of {A, Q, q_m1}). The 8-bit product register is
// written only when the fourth shift completes, and it holds between operations.

module booth_mul_ctrl_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_q,   state_d;
    logic [4:0] a_q,       a_d;
    logic [3:0] q_q,       q_d;
    logic       qm1_q,     qm1_d;
    logic [4:0] m_q,       m_d;
    logic [2:0] cnt_q,     cnt_d;
    logic [7:0] product_q, product_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    // The accumulator is 5 bits wide so that A - (-8) cannot overflow.
    logic       add_sub_select; // 0 = add M, 1 = subtract M
    logic [4:0] addend_s;
    logic [4:0] sum_s;
    logic [9:0] shifted_s;      // {A, Q, q_m1} after the arithmetic right shift

    // Add/subtract step and arithmetic-shift datapath
    always_comb begin
        add_sub_select = q_q[0] & ~qm1_q;
        addend_s       = add_sub_select ? ~m_q : m_q;
        // The carry out of bit 4 is discarded.
        sum_s          = a_q + addend_s + {4'd0, add_sub_select};
        shifted_s      = {a_q[4], a_q, q_q};
    end

    // Controller sequencing and next-value selection for all registers
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[3], multiplicand};
                    q_d     = multiplier;
                    a_d     = 5'd0;
                    qm1_d   = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                case ({q_q[0], qm1_q})
                    2'b01:   a_d = sum_s;
                    2'b10:   a_d = sum_s;
                    default: a_d = a_q;
                endcase
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_d   = shifted_s[9:5];
                q_d   = shifted_s[4:1];
                qm1_d = shifted_s[0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    // Low 4 bits of shifted A and all of shifted Q form the product.
                    product_d = shifted_s[8:1];
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of where the FSM is headed.
        busy_d = (state_d != ST_IDLE) ? 1'b1 : 1'b0;
        done_d = (state_d == ST_DONE) ? 1'b1 : 1'b0;
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= 5'd0;
            q_q       <= 4'd0;
            qm1_q     <= 1'b0;
            m_q       <= 5'd0;
            cnt_q     <= 3'd0;
            product_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
